gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised successor to the single 2-bit saturating-counter predictor.
- A gshare direction predictor: a pattern history table (PHT) of 2^IDX_W saturating counters, indexed by PC XOR global history register (GHR).
- Sits beside fetch. It takes a prediction request per cycle and a resolved-branch update per cycle from execute.
- Includes a PHT initialisation sweep after reset and on flush.

Parameters:
- PC_W, 32, fetch PC width.
- IDX_W, 6, PHT index width; PHT depth = 2^IDX_W.
- CTR_W, 2, saturating counter width (>=1).
- HIST_W, 6, GHR length; must be <= IDX_W.
- CTR_INIT, 2^CTR_W-1, counter value written by the init sweep (default strongly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous request to re-initialise the PHT and clear the GHR.
- ready  out  1  high when the PHT is initialised and requests are accepted.
- req_valid  in  1  prediction request.
- req_pc  in  PC_W  PC of the branch being predicted.
- pred_valid  out  1  prediction result valid, one cycle after an accepted request.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_idx  out  IDX_W  PHT index used; returned with the update.
- upd_valid  in  1  resolved-branch update.
- upd_idx  in  IDX_W  index previously returned on pred_idx.
- upd_taken  in  1  actual branch outcome.

Behaviour:
- Reset (rst_n=0, async):
  - state=INIT, sweep_ptr=0, GHR=0.
  - ready=0, pred_valid=0, pred_taken=0, pred_idx=0.
  - PHT contents are undefined until the sweep completes.
- FSM states: INIT, READY.
  - INIT: each cycle write CTR_INIT to PHT[sweep_ptr], then sweep_ptr++.
  - The cycle that writes entry 2^IDX_W-1 moves to READY.
  - ready is registered and =1 exactly 2^IDX_W cycles after rst_n deasserts.
  - In INIT, req_valid and upd_valid are ignored; pred_valid stays 0 and the GHR is not shifted.
  - READY + flush=1: next state INIT, sweep_ptr=0, GHR=0, pred_valid=0 next cycle. Any same-cycle req or upd is dropped.
  - flush during INIT restarts the sweep from 0.
- Index: idx = req_pc[IDX_W+1:2] XOR {(IDX_W-HIST_W) zeros, GHR}. PC bits [1:0] are ignored.
- Prediction, READY only, latency 1:
  - req_valid at cycle N gives, at edge N+1: pred_valid=1, pred_taken=PHT[idx][CTR_W-1], pred_idx=idx.
  - pred_valid=0 in cycles without an accepted request.
  - pred_taken and pred_idx hold their last value when pred_valid=0.
- Update, READY only, applied at the edge:
  - upd_taken=1: PHT[upd_idx] += 1 unless it equals 2^CTR_W-1 (saturate).
  - upd_taken=0: PHT[upd_idx] -= 1 unless it equals 0 (saturate).
  - GHR <= {GHR[HIST_W-2:0], upd_taken}, shifting in at the LSB. The GHR is non-speculative.
- Simultaneous req and upd in the same cycle:
  - The request index uses the GHR value before the shift.
  - The PHT read returns the pre-update counter, including when idx == upd_idx (read-before-write, no bypass).
- Width rule: counter arithmetic is CTR_W bits with explicit saturation checks; it never wraps.
- Reset mid-sweep or mid-operation: immediately returns to the reset state above; the sweep restarts.

Decomposition:
- Package bp_pkg:
  - state enum {INIT, READY};
  - function gshare_index(pc, ghr);
  - function sat_update(ctr, taken), parameterised by CTR_W via width-generic coding.
- One natural sub-module, bp_pht: the 2^IDX_W x CTR_W register array.
  - One combinational read port.
  - One write port, muxed between the sweep write and the saturating update.
- FSM, GHR and output registers live in gshare_predictor.

Test Plan:
- Reset release: rst_n rising -> ready=0 for 64 cycles, ready=1 on cycle 64; pred_valid stays 0 for req_valid pulses during INIT.
- First prediction: req_pc=0x0000_0010 at GHR=0 -> next cycle pred_valid=1, pred_idx=4, pred_taken=1 (CTR_INIT=3).
- Saturation:
  - three upd_taken=0 to idx 4 -> counter 0;
  - a fourth -> stays 0, predict 0;
  - four upd_taken=1 -> counter 3, not wrapped to 0.
- GHR hashing: updates taken,not,taken (GHR=0b000101), then req_pc=0x10 -> pred_idx=4 XOR 5 = 1.
- Same-cycle collision: counter at idx 1 = 2, req to idx 1 with upd_idx=1, upd_taken=0 -> pred_taken=1 (old value); next read gives 0.
- Flush / reset mid-sweep:
  - flush in READY -> ready=0 next cycle, re-ready 64 cycles later, GHR=0, all entries =3;
  - rst_n pulse at sweep_ptr=20 -> sweep restarts, ready after 64 further cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// Helpers are width-generic; callers truncate the result to their own width.
package bp_pkg;

    typedef enum logic {INIT, READY} state_t;

    // PC bits [1:0] never select an entry. The caller keeps the low IDX_W bits,
    // so a GHR shorter than the index lands in the low bits only.
    function automatic logic [63:0] gshare_index(input logic [63:0] pc,
                                                 input logic [63:0] ghr);
        return (pc >> 2) ^ ghr;
    endfunction

    function automatic logic [31:0] sat_update(input logic [31:0]  ctr,
                                               input logic         taken,
                                               input int unsigned  ctr_w);
        logic [31:0] max_val;
        max_val = (32'd1 << ctr_w) - 32'd1;
        if (taken)
            return (ctr == max_val) ? ctr : ctr + 32'd1;
        else
            return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W saturating counters, one combinational read
// port and one write port (init-sweep value or saturating read-modify-write).
module bp_pht #(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic             wr_sweep,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CTR_W-1:0] wr_init,
    input  logic             wr_taken
);
    import bp_pkg::*;

    logic [CTR_W-1:0] mem [2**IDX_W];
    logic [CTR_W-1:0] wr_data;

    assign rd_ctr = mem[rd_idx];

    always_comb begin
        wr_data = CTR_W'(sat_update(32'(mem[wr_idx]), wr_taken, CTR_W));
        if (wr_sweep)
            wr_data = wr_init;
    end

    // Contents are deliberately not reset; the init sweep defines them.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT indexed by PC XOR a non-speculative GHR,
// with a one-entry-per-cycle PHT initialisation sweep after reset and flush.
module gshare_predictor #(
    parameter int PC_W     = 32,
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 6,
    parameter int CTR_INIT = (1 << CTR_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             ready,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    import bp_pkg::*;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  sweep_ptr;
    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  pht_wr_idx;
    logic [CTR_W-1:0]  rd_ctr;
    logic              in_ready, req_acc, upd_acc, pht_sweep, pht_wr_en;

    // Flush in READY drops any request or update presented in the same cycle.
    assign in_ready = (state == READY);
    assign req_acc  = in_ready && !flush && req_valid;
    assign upd_acc  = in_ready && !flush && upd_valid;
    assign ready    = in_ready;

    // Index uses the pre-shift GHR, so a same-cycle update never affects it.
    assign req_idx    = IDX_W'(gshare_index(64'(req_pc), 64'(ghr)));
    assign pht_sweep  = (state == INIT);
    assign pht_wr_en  = pht_sweep || upd_acc;
    assign pht_wr_idx = pht_sweep ? sweep_ptr : upd_idx;

    bp_pht #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk      (clk),
        .rd_idx   (req_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (pht_wr_en),
        .wr_sweep (pht_sweep),
        .wr_idx   (pht_wr_idx),
        .wr_init  (CTR_W'(CTR_INIT)),
        .wr_taken (upd_taken)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (!flush && sweep_ptr == '1) state_nxt = READY;
            READY:   if (flush) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= INIT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_ptr <= '0;
            ghr       <= '0;
        end else begin
            if (flush || state == READY)
                sweep_ptr <= '0;
            else
                sweep_ptr <= sweep_ptr + IDX_W'(1);

            if (flush)
                ghr <= '0;
            else if (upd_acc)
                ghr <= HIST_W'({ghr, upd_taken});
        end
    end

    // Stage p1: prediction registers; the PHT read is pre-update (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= req_acc;
            if (req_acc) begin
                pred_taken <= rd_ctr[CTR_W-1];
                pred_idx   <= req_idx;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed vector tables, flush and
// reset-mid-sweep sequences, then random traffic against a behavioural model.
module tb_gshare_predictor;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n, flush, ready;
    logic        req_valid, pred_valid, pred_taken;
    logic [31:0] req_pc;
    logic [5:0]  pred_idx, upd_idx;
    logic        upd_valid, upd_taken;

    int checks   = 0;
    int failures = 0;

    int m_pht [DEPTH];
    int m_ghr, m_pt, m_pidx;

    typedef struct {
        bit rv;
        int pc;
        bit uv;
        int ui;
        bit ut;
        bit epv;
        bit ept;
        int eidx;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    gshare_predictor #(
        .PC_W   (32),
        .IDX_W  (6),
        .CTR_W  (2),
        .HIST_W (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .ready      (ready),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_pc    = 32'h0;
        upd_valid = 1'b0;
        upd_idx   = 6'd0;
        upd_taken = 1'b0;
    endtask

    function automatic vec_t mk(bit rv, int pc, bit uv, int ui, bit ut,
                                bit epv, bit ept, int eidx);
        vec_t v;
        v.rv = rv; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut;
        v.epv = epv; v.ept = ept; v.eidx = eidx;
        return v;
    endfunction

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            req_pc    = 32'(tbl[i].pc);
            upd_valid = tbl[i].uv;
            upd_idx   = 6'(tbl[i].ui);
            upd_taken = tbl[i].ut;
            tick();
            chk($sformatf("%s[%0d].pred_valid", tag, i), int'(pred_valid), int'(tbl[i].epv));
            chk($sformatf("%s[%0d].pred_taken", tag, i), int'(pred_taken), int'(tbl[i].ept));
            chk($sformatf("%s[%0d].pred_idx", tag, i), int'(pred_idx), tbl[i].eidx);
            idle_inputs();
        end
        tbl.delete();
    endtask

    // Wait out a 64-entry sweep; ready must rise on exactly the 64th edge.
    task automatic sweep_wait(input string tag, input bit poke);
        for (int k = 1; k <= DEPTH; k++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_pc    = $urandom;
                upd_valid = 1'b1;
                upd_idx   = 6'($urandom_range(0, 63));
                upd_taken = 1'b0;
            end
            tick();
            chk($sformatf("%s.ready@%0d", tag, k), int'(ready), (k == DEPTH) ? 1 : 0);
            if (poke)
                chk($sformatf("%s.pred_valid@%0d", tag, k), int'(pred_valid), 0);
            idle_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int idx;
        bit rv, uv, ut;
        int ui;
        logic [31:0] pc;

        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("reset.ready", int'(ready), 0);
        chk("reset.pred_valid", int'(pred_valid), 0);
        chk("reset.pred_taken", int'(pred_taken), 0);
        chk("reset.pred_idx", int'(pred_idx), 0);

        // Release reset; requests and updates during INIT must be ignored.
        rst_n = 1'b1;
        sweep_wait("init", 1'b1);

        // Saturation and hashing, GHR starts at 0, all counters 3.
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 1, 1, 4));
        tbl.push_back(mk(0, 0,    1, 4, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0,    1, 4, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0,    1, 4, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0,    1, 4, 0, 0, 1, 4));
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0,    1, 4, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0,    1, 4, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0,    1, 4, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0,    1, 4, 1, 0, 0, 4));
        tbl.push_back(mk(1, 'h2C, 0, 0, 0, 1, 1, 4));
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 1, 1, 11));
        tbl.push_back(mk(0, 0,    1, 4, 0, 0, 1, 11));
        tbl.push_back(mk(1, 'h68, 0, 0, 0, 1, 1, 4));
        run_table("sat");

        // Flush in READY with a same-cycle request and update, both dropped.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h10;
        upd_valid = 1'b1;
        upd_idx   = 6'd4;
        upd_taken = 1'b0;
        tick();
        idle_inputs();
        chk("flush.ready", int'(ready), 0);
        chk("flush.pred_valid", int'(pred_valid), 0);
        sweep_wait("flush", 1'b0);

        // GHR hashing and same-cycle read-before-write collision.
        tbl.push_back(mk(0, 0,    1, 10, 1, 0, 1, 4));
        tbl.push_back(mk(0, 0,    1, 20, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0,    1, 30, 1, 0, 1, 4));
        tbl.push_back(mk(1, 'h10, 0, 0,  0, 1, 1, 1));
        tbl.push_back(mk(0, 0,    1, 1,  0, 0, 1, 1));
        tbl.push_back(mk(1, 'h2C, 1, 1,  0, 1, 1, 1));
        tbl.push_back(mk(1, 'h54, 0, 0,  0, 1, 0, 1));
        tbl.push_back(mk(1, 'h00, 0, 0,  0, 1, 1, 20));
        tbl.push_back(mk(1, 'h03, 0, 0,  0, 1, 1, 20));
        run_table("hash");

        // Reset asserted part-way through a sweep (sweep_ptr = 20).
        flush = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 20; k++)
            tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.ready", int'(ready), 0);
        chk("midrst.pred_valid", int'(pred_valid), 0);
        chk("midrst.pred_taken", int'(pred_taken), 0);
        chk("midrst.pred_idx", int'(pred_idx), 0);
        tick();
        rst_n = 1'b1;
        sweep_wait("midrst", 1'b0);

        // Random traffic against the behavioural model.
        for (int i = 0; i < DEPTH; i++)
            m_pht[i] = 3;
        m_ghr  = 0;
        m_pt   = 0;
        m_pidx = 0;
        for (int n = 0; n < 400; n++) begin
            rv  = 1'($urandom_range(0, 1));
            uv  = 1'($urandom_range(0, 1));
            ut  = 1'($urandom_range(0, 1));
            pc  = $urandom;
            idx = (int'(pc[31:2]) ^ m_ghr) & (DEPTH - 1);
            ui  = ($urandom_range(0, 3) == 0) ? idx : int'($urandom_range(0, 7));

            if (rv) begin
                m_pt   = (m_pht[idx] >= 2) ? 1 : 0;
                m_pidx = idx;
            end
            if (uv) begin
                if (ut && m_pht[ui] < 3)
                    m_pht[ui] = m_pht[ui] + 1;
                else if (!ut && m_pht[ui] > 0)
                    m_pht[ui] = m_pht[ui] - 1;
                m_ghr = (m_ghr * 2 + int'(ut)) % DEPTH;
            end

            req_valid = rv;
            req_pc    = pc;
            upd_valid = uv;
            upd_idx   = 6'(ui);
            upd_taken = ut;
            tick();
            chk($sformatf("rand[%0d].pred_valid", n), int'(pred_valid), int'(rv));
            chk($sformatf("rand[%0d].pred_taken", n), int'(pred_taken), m_pt);
            chk($sformatf("rand[%0d].pred_idx", n), int'(pred_idx), m_pidx);
            idle_inputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
